// File: rtl/cla_pkg.sv
// Shared configuration and elaboration helpers for the pipelined CLA adder.
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 32;
    localparam int unsigned CLA_GROUP = 4;
    localparam int unsigned CLA_GPS   = 2;

    // Pipeline depth: one stage per GROUP*GPS bits.
    function automatic int unsigned cla_stages(input int unsigned width,
                                               input int unsigned group,
                                               input int unsigned gps);
        return width / (group * gps);
    endfunction

    // Legal when every stage covers a whole number of groups and width is non-empty.
    function automatic bit cla_cfg_ok(input int unsigned width,
                                      input int unsigned group,
                                      input int unsigned gps);
        return (width != 0) && (group != 0) && (gps != 0) && ((width % (group * gps)) == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-look-ahead block with group generate/propagate.
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             g,
    output logic             p,
    output logic             cout
);

    logic [GROUP-1:0] gen;
    logic [GROUP-1:0] prop;
    logic [GROUP:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Group generate/propagate depend only on the operands, never on cin,
    // so the stage-level chain above this block stays loop-free.
    always_comb begin
        logic gi;
        logic pi;
        gi = 1'b0;
        pi = 1'b1;
        for (int j = 0; j < GROUP; j++) begin
            gi = gen[j] | (prop[j] & gi);
            pi = pi & prop[j];
        end
        g = gi;
        p = pi;
    end

    // Each carry in closed look-ahead form from the bits below it and cin.
    always_comb begin
        logic gi;
        logic pi;
        carry[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            gi = 1'b0;
            pi = 1'b1;
            for (int j = 0; j <= i; j++) begin
                gi = gen[j] | (prop[j] & gi);
                pi = pi & prop[j];
            end
            carry[i+1] = gi | (pi & cin);
        end
    end

    assign sum  = prop ^ carry[GROUP-1:0];
    assign cout = carry[GROUP];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-look-ahead add/subtract unit; one slice of GROUP*GPS bits per stage.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_WIDTH,
    parameter int unsigned GROUP = CLA_GROUP,
    parameter int unsigned GPS   = CLA_GPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SW     = GROUP * GPS;
    localparam int unsigned STAGES = cla_stages(WIDTH, GROUP, GPS);

    if (!cla_cfg_ok(WIDTH, GROUP, GPS)) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP*GPS");
    end

    // Whole pipeline moves together; a full output slot blocks every stage.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * SW;

        logic             v_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;

        logic [GPS-1:0]   gg;
        logic [GPS-1:0]   gp;
        logic [GPS-1:0]   gco;
        logic [GPS:0]     gc;
        logic [SW-1:0]    slice;
        logic [WIDTH-1:0] s_next;

        logic             v_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;

        if (k == 0) begin : g_head
            // Subtract is A + ~B + 1, so cin is overridden by sub.
            assign v_in = in_valid;
            assign a_in = a;
            assign b_in = b ^ {WIDTH{sub}};
            assign s_in = '0;
            assign c_in = sub | cin;
        end else begin : g_body
            assign v_in = g_stage[k-1].v_q;
            assign a_in = g_stage[k-1].a_q;
            assign b_in = g_stage[k-1].b_q;
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].c_q;
        end

        for (genvar g = 0; g < GPS; g++) begin : g_grp
            cla_group #(
                .GROUP (GROUP)
            ) u_group (
                .a    (a_in[LO + g*GROUP +: GROUP]),
                .b    (b_in[LO + g*GROUP +: GROUP]),
                .cin  (gc[g]),
                .sum  (slice[g*GROUP +: GROUP]),
                .g    (gg[g]),
                .p    (gp[g]),
                .cout (gco[g])
            );
        end

        // Group-level look-ahead chain across the GPS groups of this stage.
        always_comb begin
            gc[0] = c_in;
            for (int i = 0; i < int'(GPS); i++) begin
                gc[i+1] = gg[i] | (gp[i] & gc[i]);
            end
        end

        // Splice this stage's slice into the skewed partial sum.
        always_comb begin
            s_next           = s_in;
            s_next[LO +: SW] = slice;
        end

        // Stage register: operands, partial sum and carry move only on advance.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
                a_q <= a_in;
                b_q <= b_in;
                s_q <= s_next;
                c_q <= gc[GPS];
            end
        end
    end

    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    logic             msb_cin;

    assign last_a    = g_stage[STAGES-1].a_q;
    assign last_b    = g_stage[STAGES-1].b_q;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;

    // Carry into the MSB recovered from the registered sum bit and its operands.
    assign msb_cin = last_a[WIDTH-1] ^ last_b[WIDTH-1] ^ sum[WIDTH-1];
    assign ovf     = msb_cin ^ cout;

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-look-ahead add/subtract unit.
- Successor to the fixed 32-bit ripple-of-4-bit-CLA adder.
- Operand width, CLA group size and groups-per-stage are configurable. The carry chain is registered between stages, so the clock rate is independent of width.
- Valid/ready handshake with full-pipeline backpressure. Sits in the datapath ahead of the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of GROUP*GPS.
- GROUP, 4, bits per CLA group (look-ahead span).
- GPS, 2, CLA groups evaluated per pipeline stage.
- STAGES, WIDTH/(GROUP*GPS), derived localparam; pipeline latency in cycles.

Ports:
- clk  in  1  rising-edge clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0. Any in-flight beats are discarded. in_ready is 1 in the cycle after reset.
- Accept: a beat is taken when in_valid && in_ready. Result is taken when out_valid && out_ready.
- Stall rule: in_ready = !out_valid || out_ready.
  - When in_ready=0, every stage register holds its value, including data, carries and valid bits.
  - Bubbles are not compressed; the pipeline advances as a whole.
- Latency: a beat accepted at cycle N produces out_valid at cycle N+STAGES, provided there is no stall. Throughput is one beat per cycle.
- Stage k (0..STAGES-1):
  - Computes sum bits [k*GROUP*GPS +: GROUP*GPS] from the registered carry of stage k-1. Stage 0 uses cin_eff = sub ? 1 : cin.
  - Within a stage, the GPS groups chain via group generate/propagate (Cg+1 = Gg | Pg&Cg). Stage carry-out is registered.
  - Operand bits not yet consumed, and sum bits already produced, travel in skew registers alongside the beat.
- B inversion (b ^ {WIDTH{sub}}) is applied at capture into stage 0.
- Carry into MSB is taken in the last stage for ovf. ovf is valid for both add and sub.
- Output registers update only on advance. Values are held stable while out_valid && !out_ready.
- Simultaneous accept and release in the same cycle is legal and keeps full throughput.
- in_valid=0 injects a bubble with valid=0. Data registers for that slot may update; this is don't-care.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Elaboration error if WIDTH % (GROUP*GPS) != 0.

Decomposition:
- Package cla_pkg:
  - Default WIDTH/GROUP/GPS localparams.
  - A function computing STAGES.
  - The elaboration-check macro/function.
- Sub-module cla_group: combinational GROUP-bit CLA.
  - Inputs: a, b, cin.
  - Outputs: sum, group generate G, group propagate P, cout.
  - Instantiated GPS times per stage via generate loop.
- The top contains the stage registers, skew registers and handshake.

Test Plan (WIDTH=32, GROUP=4, GPS=2, STAGES=4):
- Add with full carry propagate: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x00000000, cout=1, ovf=0.
- Signed overflow:
  - a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1.
  - sub with a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Subtract with borrow: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Also verify cin=1 is ignored when sub=1.
- Back-to-back stream then stall:
  - Issue 8 beats of random a, b.
  - Hold out_ready=0 for 3 cycles once out_valid=1 -> in_ready=0 and sum is stable during the stall.
  - Release -> all 8 results arrive in order, with no loss or duplication, matching the reference model.
- Reset mid-flight: after 3 beats are accepted, assert rst for 1 cycle -> the next cycle has out_valid=0 and sum=0, no stale beats ever emerge, and in_ready=1.
- Parameter sweep: WIDTH=16/GPS=1 (STAGES=4) and WIDTH=64/GROUP=8/GPS=8 (STAGES=1) -> latency equals STAGES, and 1000 random add/sub beats with random out_ready match the reference model.
